// File: rtl/fetch_pc_unit.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage. Owns the program counter, keeps at most one
// instruction-memory request outstanding, and hands each fetched word to
// decode. A taken branch/jump resolved in EX (redirect_valid) moves the PC to
// redirect_target. A response that belongs to the old PC is thrown away.
//
// Handshakes (both the imem request and the decode hand-off): a transfer
// happens on a rising clock edge where valid && ready are both high. While
// valid is high without ready, the producer holds its payload stable. The
// one case that breaks this is a redirect: the fetch request address may
// change while it is waiting, and if_valid drops in the cycle a redirect
// arrives.
//
// Ports
//   clk, rst_n       : clock, asynchronous active-low reset
//   redirect_valid   : taken branch/jump resolved in EX this cycle
//   redirect_target  : new PC; bits [1:0] are forced to zero
//   imem_req_valid   : fetch request valid (high only in REQ)
//   imem_req_ready   : memory accepts the request
//   imem_req_addr    : word-aligned fetch address (= pc)
//   imem_rsp_valid   : response valid; only meaningful in WAIT
//   imem_rsp_data    : instruction word returned by memory
//   if_valid         : instruction available to decode
//   if_ready         : decode consumes the instruction
//   if_pc, if_instr  : PC and word of the presented instruction
//   dbg_state        : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 HOLD)
//   dbg_drop         : outstanding response is stale and will be discarded
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [1:0]  dbg_state,
    output logic        dbg_drop
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        drop_q, drop_d;

    // Low two bits of the target are cleared by masking so that every input
    // bit is consumed and the PC always stays word aligned.
    logic [31:0] target_aligned;
    assign target_aligned = redirect_target & ~32'h0000_0003;

    logic req_fire;
    assign req_fire = (state_q == S_REQ) && imem_req_ready;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers follow the values chosen by the next-state logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            instr_q <= 32'h0000_0000;
            drop_q  <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic (FSM plus pc / instr_buf / drop updates)
    // Redirect wins over every other event except in IDLE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        drop_d  = drop_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end

            S_REQ: begin
                if (req_fire) begin
                    state_d = S_WAIT;
                    // The address that just went out is the old pc, so a
                    // redirect in this same cycle makes its answer stale.
                    drop_d  = redirect_valid;
                end
                if (redirect_valid) begin
                    pc_d = target_aligned;
                end
            end

            S_WAIT: begin
                if (imem_rsp_valid) begin
                    if (!drop_q && !redirect_valid) begin
                        instr_d = imem_rsp_data;
                        state_d = S_HOLD;
                    end else begin
                        drop_d  = 1'b0;
                        state_d = S_REQ;
                        if (redirect_valid) begin
                            pc_d = target_aligned;
                        end
                    end
                end else if (redirect_valid) begin
                    // Cannot issue the new fetch until the old response has
                    // come back; remember to discard it.
                    pc_d   = target_aligned;
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = target_aligned;
                    state_d = S_REQ;
                end else if (if_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // if_valid is masked by redirect_valid combinationally so that an
    // instruction on the wrong path is never handed to decode.
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req_valid = 1'b0;
        if_valid       = 1'b0;
        imem_req_addr  = pc_q;
        if_pc          = pc_q;
        if_instr       = instr_q;
        dbg_state      = state_q;
        dbg_drop       = drop_q;

        if (state_q == S_REQ) begin
            imem_req_valid = 1'b1;
        end
        if (state_q == S_HOLD && !redirect_valid) begin
            if_valid = 1'b1;
        end
    end

endmodule
